seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Downstream consumer of the score BCD-to-character stage and of the mode/song-name character words.
- Takes a 64-bit, 8-character seven-segment frame and time-multiplexes it onto the board's 8-digit display: one digit per scan slot, two 4-digit segment buses plus an 8-bit digit enable.
- Frame updates are double-buffered and committed only at full-scan boundaries, so digits never tear.
- Per-digit blinking supports the score, countdown and selection screens.

Parameters:
SCAN_PERIOD, 200000, clk cycles each digit stays enabled (matches scan_period constant)
BLINK_SCANS, 64, full 8-digit scans per blink half-phase
DIGITS, 8, digit count (fixed; generic only for documentation)

Ports:
clk  in  1  system clock
rst  in  1  reset
frame_in  in  64  characters; digit 0 (leftmost) = frame_in[63:56], digit 7 = frame_in[7:0]
frame_valid  in  1  one-cycle strobe, capture frame_in
blink_mask  in  8  bit i=1 -> digit i blinks (sampled live, not buffered)
seg_en  out  8  one-hot digit enable, bit i = digit i, active-high
seg_out0  out  8  segments for digits 0-3, same bit order as character words (bit7=a ... bit1=g, bit0=dp)
seg_out1  out  8  segments for digits 4-7
frame_loaded  out  1  one-cycle pulse when a new frame becomes active

Behaviour:
- Interface: one clock, clk; rst is asynchronous and active-high.
- Reset (async): tick=0, idx=0, active=0, shadow=0, pending=0, blink_cnt=0, phase=0. All outputs 0 while rst is high.
- tick counts 0..SCAN_PERIOD-1. On the terminal count (scan_step) tick wraps to 0 and idx advances 0..7, then 7->0 (scan_wrap).
- Outputs are registered from idx/active/phase, one cycle of latency:
  - seg_en = 1<<idx.
  - The segment bus owning idx (idx<4 -> seg_out0, else seg_out1) = active[63-8*idx -: 8], zeroed if blink_mask[idx]&phase.
  - The other bus = 0.
  - First cycle after rst release: seg_en=8'h01, both buses 0.
- Frame capture: frame_valid=1 -> shadow<=frame_in, pending<=1. A later valid before commit overwrites shadow; last one wins.
- Commit: on scan_wrap with pending=1 -> active<=shadow, pending<=0, frame_loaded=1 for exactly that cycle (registered).
- Simultaneous frame_valid and scan_wrap: frame_in bypasses straight into active, pending<=0, frame_loaded=1. The older shadow is discarded.
- No frame_valid ever: active holds its value forever. No frame_loaded pulses.
- Blink: blink_cnt counts scan_wrap events 0..BLINK_SCANS-1. At the terminal value it wraps and phase toggles.
  - blink_mask=0 -> phase has no visible effect.
  - A blink_mask change takes effect at the next registered output update.
- rst asserted mid-scan: immediate return to the reset state. A pending shadow is lost.
- Arithmetic: tick width = clog2(SCAN_PERIOD); idx 3 bits; blink_cnt = clog2(BLINK_SCANS). All counters wrap modulo their limits, with no overflow states.
- The block does no character decoding. All-zero characters display as blank.

Decomposition:
- Shared package (parameters.v):
  - scan_period (default for SCAN_PERIOD).
  - New constant blink_scans.
  - Existing character constants (ZERO..NINE, SEP), used by the bench only.
- Sub-module scan_divider: generic modulo-N tick counter with a terminal-count strobe. Instantiated twice:
  - N=SCAN_PERIOD on clk, producing scan_step.
  - N=BLINK_SCANS enabled by scan_wrap, producing the phase toggle.
- All remaining logic (shadow/commit, idx, output mux) sits in seg_scan_driver.

Test Plan (SCAN_PERIOD=4, BLINK_SCANS=2 unless stated):
1. Reset then idle 40 cycles:
   - seg_en steps 01,02,04,...,80,01, each held 4 cycles.
   - seg_out0 = seg_out1 = 0 throughout.
   - frame_loaded never pulses.
2. Load ZERO,ONE,...,SEVEN (frame_valid at cycle 5):
   - frame_loaded pulses once, at the first scan_wrap after cycle 5.
   - Next scan: seg_out0 = FC,60,DA,F2 with seg_en 01..08; seg_out1 = 66,B6,BE,E0 with seg_en 10..80.
   - The inactive bus reads 0 in every slot.
3. Two frame_valid strobes (all-ONE, then all-TWO) inside one scan:
   - Single frame_loaded pulse.
   - All digits show DA on the next scan.
4. frame_valid (all-EIGHT) on the exact scan_wrap cycle while a different frame is pending:
   - EIGHT (FE) is displayed from the immediately following scan.
   - The pending frame is never shown.
5. blink_mask=8'h81 with frame all-NINE:
   - Digits 0 and 7 alternate F6 / 00 every 2 full scans.
   - Digits 1-6 always F6.
6. rst pulsed mid-scan while pending=1:
   - Outputs 0 immediately, asynchronously, without waiting for a clk edge.
   - After release: seg_en=01, segments 0, no frame_loaded until a new frame_valid.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver.
//   scan_period : default clk cycles per digit slot
//   blink_scans : default full scans per blink half-phase
//   ZERO..NINE, SEP : character words (bit7=a ... bit1=g, bit0=dp)
//   cnt_width() : counter width helper, at least 1 bit even for N=1
package seg_scan_driver_pkg;

  localparam int scan_period = 200000;
  localparam int blink_scans = 64;

  localparam logic [7:0] ZERO  = 8'hFC;
  localparam logic [7:0] ONE   = 8'h60;
  localparam logic [7:0] TWO   = 8'hDA;
  localparam logic [7:0] THREE = 8'hF2;
  localparam logic [7:0] FOUR  = 8'h66;
  localparam logic [7:0] FIVE  = 8'hB6;
  localparam logic [7:0] SIX   = 8'hBE;
  localparam logic [7:0] SEVEN = 8'hE0;
  localparam logic [7:0] EIGHT = 8'hFE;
  localparam logic [7:0] NINE  = 8'hF6;
  localparam logic [7:0] SEP   = 8'h02;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_scan_divider.sv
// scan_divider: generic modulo-N counter with a terminal-count strobe.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; the counter only moves when en=1
//   tc       : high for the enabled cycle in which the count is N-1
//              (the counter wraps to 0 on that edge)
module scan_divider
  import seg_scan_driver_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(N);

  logic [CW-1:0] count;

  assign tc = en && (count == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (tc) count <= '0;
      else    count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes a 64-bit, 8-character frame onto an
// 8-digit seven-segment display with double-buffered frame updates and
// per-digit blinking.
//   clk, rst     : clock, asynchronous active-high reset
//   frame_in     : characters, digit 0 (leftmost) = frame_in[63:56]
//   frame_valid  : one-cycle capture strobe
//   blink_mask   : bit i=1 -> digit i blinks (used live, not buffered)
//   seg_en       : one-hot digit enable, bit i = digit i
//   seg_out0     : segments for digits 0-3 (0 while digits 4-7 scan)
//   seg_out1     : segments for digits 4-7 (0 while digits 0-3 scan)
//   frame_loaded : one-cycle pulse when a new frame becomes active
//
// Handshake: frame_valid is a fire-and-forget strobe with no ready; every
// cycle it is high, frame_in is taken. Captured frames wait in a shadow
// register and are committed only at the end of a full 8-digit scan, so a
// scan never mixes two frames; the last strobe before the commit wins.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_PERIOD = scan_period,
  parameter int BLINK_SCANS = blink_scans,
  parameter int DIGITS      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] frame_in,
  input  logic        frame_valid,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out0,
  output logic [7:0]  seg_out1,
  output logic        frame_loaded
);

  localparam int IW = cnt_width(DIGITS);

  logic [IW-1:0] idx;
  logic [63:0]   active;
  logic [63:0]   shadow;
  logic          pending;
  logic          phase;
  logic          scan_step;
  logic          scan_wrap;
  logic          phase_flip;
  logic [7:0]    cur_char;
  logic          blanked;

  scan_divider #(.N(SCAN_PERIOD)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .tc  (scan_step)
  );

  assign scan_wrap = scan_step && (idx == IW'(DIGITS - 1));

  // Counts completed scans; its terminal strobe flips the blink phase.
  scan_divider #(.N(BLINK_SCANS)) u_blink (
    .clk (clk),
    .rst (rst),
    .en  (scan_wrap),
    .tc  (phase_flip)
  );

  always_comb begin
    cur_char = active[8 * (DIGITS - 1 - int'(idx)) +: 8];
    blanked  = blink_mask[idx] & phase;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      active       <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      phase        <= 1'b0;
      frame_loaded <= 1'b0;
      seg_en       <= '0;
      seg_out0     <= '0;
      seg_out1     <= '0;
    end else begin
      if (scan_step) begin
        idx <= scan_wrap ? '0 : idx + 1'b1;
      end

      if (phase_flip) phase <= ~phase;

      // A strobe landing on the wrap cycle goes straight to the display;
      // whatever sat in the shadow is superseded and dropped.
      if (frame_valid && scan_wrap) begin
        active       <= frame_in;
        pending      <= 1'b0;
        frame_loaded <= 1'b1;
      end else if (scan_wrap && pending) begin
        active       <= shadow;
        pending      <= 1'b0;
        frame_loaded <= 1'b1;
      end else begin
        frame_loaded <= 1'b0;
        if (frame_valid) begin
          shadow  <= frame_in;
          pending <= 1'b1;
        end
      end

      // Outputs reflect the slot being scanned this cycle, one cycle late.
      seg_en   <= 8'b1 << idx;
      seg_out0 <= (!idx[IW-1] && !blanked) ? cur_char : 8'h00;
      seg_out1 <= ( idx[IW-1] && !blanked) ? cur_char : 8'h00;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with SCAN_PERIOD=4, BLINK_SCANS=2.
// The reference derives the displayed slot, blink phase and commit points
// purely from the number of clock edges since reset release.
module tb_seg_scan_driver;
  import seg_scan_driver_pkg::*;

  localparam int P    = 4;
  localparam int B    = 2;
  localparam int SCAN = 8 * P;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic [7:0]  blink_mask;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out0;
  logic [7:0]  seg_out1;
  logic        frame_loaded;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_PERIOD(P), .BLINK_SCANS(B), .DIGITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_in     (frame_in),
    .frame_valid  (frame_valid),
    .blink_mask   (blink_mask),
    .seg_en       (seg_en),
    .seg_out0     (seg_out0),
    .seg_out1     (seg_out1),
    .frame_loaded (frame_loaded)
  );

  // ---------------- reference state ----------------
  int          checks   = 0;
  int          failures = 0;
  int          k;          // clock edges since reset release
  logic [63:0] m_active;
  logic [63:0] m_shadow;
  logic        m_pend;
  int          loads;      // frame_loaded pulses seen

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [63:0] fill(input logic [7:0] c);
    return {8{c}};
  endfunction

  // ---------------- driver / scoreboard ----------------
  // One clock: inputs held now are sampled at the next edge, then the
  // outputs produced by that edge are compared against the reference.
  task automatic step();
    logic        fv;
    logic [63:0] fin;
    logic [7:0]  mk;
    int          slot;
    int          ph;
    logic [7:0]  ch;
    logic [7:0]  e_en;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic        e_fl;
    bit          wrap;
    fv  = frame_valid;
    fin = frame_in;
    mk  = blink_mask;
    @(posedge clk);
    #1;
    k++;
    slot = ((k - 1) / P) % 8;
    ph   = (((k - 1) / SCAN) / B) % 2;
    ch   = m_active[8 * (7 - slot) +: 8];
    if (mk[slot] && ph == 1) ch = 8'h00;
    e_en = 8'(1 << slot);
    e0   = (slot < 4)  ? ch : 8'h00;
    e1   = (slot >= 4) ? ch : 8'h00;
    wrap = ((k % SCAN) == 0);
    e_fl = wrap && (m_pend || fv);
    if (wrap && fv) begin
      m_active = fin;
      m_pend   = 1'b0;
    end else if (wrap && m_pend) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end else if (fv) begin
      m_shadow = fin;
      m_pend   = 1'b1;
    end
    if (frame_loaded === 1'b1) loads++;
    check8("seg_en", seg_en, e_en);
    check8("seg_out0", seg_out0, e0);
    check8("seg_out1", seg_out1, e1);
    check8("frame_loaded", {7'd0, frame_loaded}, {7'd0, e_fl});
    frame_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge lands on scan position 'pos' (0 = wrap edge).
  task automatic run_to(input int pos);
    for (int i = 0; i < SCAN; i++) begin
      if (((k + 1) % SCAN) == pos) break;
      step();
    end
  endtask

  task automatic load(input logic [63:0] f);
    frame_in    = f;
    frame_valid = 1'b1;
    step();
  endtask

  task automatic model_reset();
    k        = 0;
    m_active = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check8({tag, "_seg_en"}, seg_en, 8'h00);
    check8({tag, "_seg_out0"}, seg_out0, 8'h00);
    check8({tag, "_seg_out1"}, seg_out1, 8'h00);
    check8({tag, "_frame_loaded"}, {7'd0, frame_loaded}, 8'h00);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int loads_before;
    rst         = 1'b1;
    frame_in    = '0;
    frame_valid = 1'b0;
    blink_mask  = '0;
    model_reset();
    loads = 0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: blank digits, plain scan order, no loads.
    run(40);
    check8("idle_loads", 8'(loads), 8'd0);

    // ZERO..SEVEN arriving at cycle 5.
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(4);
    load({ZERO, ONE, TWO, THREE, FOUR, FIVE, SIX, SEVEN});
    run(2 * SCAN);

    // Two strobes within one scan: last one wins, single commit.
    run_to(3);
    loads_before = loads;
    load(fill(ONE));
    run(5);
    load(fill(TWO));
    run(2 * SCAN);
    check8("double_strobe_loads", 8'(loads - loads_before), 8'd1);

    // Strobe exactly on the wrap cycle while another frame is pending.
    run_to(4);
    load(64'h0123_4567_89AB_CDEF);
    run_to(0);
    load(fill(EIGHT));
    run(SCAN + 5);

    // Blinking digits 0 and 7 over several blink periods.
    blink_mask = 8'h81;
    load(fill(NINE));
    run(5 * SCAN);

    // Randomized frames, strobe timing and masks.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        frame_in    = {$urandom, $urandom};
        frame_valid = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) blink_mask = 8'($urandom);
      step();
    end

    // Reset mid-scan with a frame pending.
    blink_mask = '0;
    run_to(10);
    load({$urandom, $urandom});
    run(3);
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    loads_before = loads;
    run(2 * SCAN);
    check8("post_reset_loads", 8'(loads - loads_before), 8'd0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound in case stimulus never completes.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
